// File: rtl/fpu.sv
// Two-stage binary32 add/sub/mul/div unit: operands are registered, the result is
// computed combinationally with round-to-nearest-even and flush-to-zero, then registered.
module fpu (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  opcode,
   output logic [31:0] O
);

   localparam logic [1:0]  OP_ADD = 2'b00;
   localparam logic [1:0]  OP_SUB = 2'b01;
   localparam logic [1:0]  OP_MUL = 2'b10;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

   logic [31:0] a_d, a_q, b_d, b_q, o_d, o_q;
   logic [1:0]  op_d, op_q;

   always_comb begin
      a_d  = A;
      b_d  = B;
      op_d = opcode;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
         o_q  <= '0;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         op_q <= op_d;
         o_q  <= o_d;
      end
   end

   assign O = o_q;

   // Operand decode; exponent field 0 (zero or denormal) is treated as signed zero.
   logic        sa, sb, sb_eff;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;
   logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic signed [11:0] ea_x, eb_x;

   always_comb begin
      sa     = a_q[31];
      sb     = b_q[31];
      sb_eff = b_q[31] ^ (op_q == OP_SUB);
      ea     = a_q[30:23];
      eb     = b_q[30:23];
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
      a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
      ma     = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
      mb     = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
      ea_x   = {4'd0, ea};
      eb_x   = {4'd0, eb};
   end

   // Add/sub: 27-bit working mantissa = 24 significant bits + guard, round, sticky.
   logic        add_swap, s_big, eff_sub, add_zero, lz_found;
   logic [7:0]  e_big, e_small, exp_diff;
   logic [23:0] m_big, m_small;
   logic [4:0]  shamt, lz;
   logic [50:0] small_wide;
   logic [26:0] small_al, add_n;
   logic [27:0] add_raw;
   logic signed [11:0] e_big_x, add_exp;

   always_comb begin
      add_swap   = {eb, mb} > {ea, ma};
      s_big      = add_swap ? sb_eff : sa;
      e_big      = add_swap ? eb : ea;
      e_small    = add_swap ? ea : eb;
      m_big      = add_swap ? mb : ma;
      m_small    = add_swap ? ma : mb;
      e_big_x    = {4'd0, e_big};
      eff_sub    = sa ^ sb_eff;
      exp_diff   = e_big - e_small;
      shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
      small_wide = {m_small, 27'd0} >> shamt;
      small_al   = {small_wide[50:25], |small_wide[24:0]};
      if (eff_sub) begin
         add_raw = {1'b0, m_big, 3'b000} - {1'b0, small_al};
      end else begin
         add_raw = {1'b0, m_big, 3'b000} + {1'b0, small_al};
      end
      add_zero = (add_raw == 28'd0);

      lz       = 5'd0;
      lz_found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!lz_found) begin
            if (add_raw[i]) begin
               lz_found = 1'b1;
            end else begin
               lz = lz + 5'd1;
            end
         end
      end

      if (add_raw[27]) begin
         add_n   = {add_raw[27:2], add_raw[1] | add_raw[0]};
         add_exp = e_big_x + 12'sd1;
      end else begin
         add_n   = add_raw[26:0] << lz;
         add_exp = e_big_x - {7'd0, lz};
      end
   end

   // Multiply: product lies in [2^46, 2^48), so normalisation is at most one place.
   logic [47:0] prod;
   logic [26:0] mul_n;
   logic signed [11:0] mul_exp;

   always_comb begin
      prod    = ma * mb;
      mul_n   = prod[47] ? {prod[47:22], |prod[21:0]} : {prod[46:21], |prod[20:0]};
      mul_exp = ea_x + eb_x - 12'sd127 + {11'd0, prod[47]};
   end

   // Restoring divide of ma*2^25 by mb; quotient lies in (2^24, 2^26).
   logic [24:0] rem;
   logic [25:0] quo;
   logic        div_sticky;
   logic [26:0] div_n;
   logic signed [11:0] div_exp;

   always_comb begin
      rem = {1'b0, ma};
      quo = '0;
      for (int i = 25; i >= 0; i--) begin
         if (rem >= {1'b0, mb}) begin
            quo[i] = 1'b1;
            rem    = rem - {1'b0, mb};
         end
         rem = rem << 1;
      end
      div_sticky = (rem != 25'd0);
      div_n      = quo[25] ? {quo, div_sticky} : {quo[24:0], 1'b0, div_sticky};
      div_exp    = ea_x - eb_x + 12'sd127 - {11'd0, ~quo[25]};
   end

   // Special-case selection, then one shared rounding and packing stage.
   logic        res_sign, res_zero, res_special, round_up;
   logic [31:0] special_val;
   logic [26:0] res_n;
   logic [23:0] m24;
   logic [24:0] mr;
   logic [22:0] frac_r;
   logic signed [11:0] res_exp, exp_r;

   always_comb begin
      res_sign    = 1'b0;
      res_zero    = 1'b0;
      res_special = 1'b0;
      special_val = QNAN;
      res_exp     = '0;
      res_n       = '0;

      case (op_q)
         OP_ADD, OP_SUB: begin
            if (a_nan || b_nan) begin
               res_special = 1'b1;
            end else if (a_inf && b_inf) begin
               res_special = 1'b1;
               special_val = (sa == sb_eff) ? {sa, 8'hFF, 23'd0} : QNAN;
            end else if (a_inf) begin
               res_special = 1'b1;
               special_val = {sa, 8'hFF, 23'd0};
            end else if (b_inf) begin
               res_special = 1'b1;
               special_val = {sb_eff, 8'hFF, 23'd0};
            end else begin
               res_sign = add_zero ? (sa & sb_eff) : s_big;
               res_zero = add_zero;
               res_exp  = add_exp;
               res_n    = add_n;
            end
         end
         OP_MUL: begin
            res_sign = sa ^ sb;
            if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
               res_special = 1'b1;
            end else if (a_inf || b_inf) begin
               res_special = 1'b1;
               special_val = {res_sign, 8'hFF, 23'd0};
            end else if (a_zero || b_zero) begin
               res_zero = 1'b1;
            end else begin
               res_exp = mul_exp;
               res_n   = mul_n;
            end
         end
         default: begin
            res_sign = sa ^ sb;
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
               res_special = 1'b1;
            end else if (a_inf || b_zero) begin
               res_special = 1'b1;
               special_val = {res_sign, 8'hFF, 23'd0};
            end else if (b_inf || a_zero) begin
               res_zero = 1'b1;
            end else begin
               res_exp = div_exp;
               res_n   = div_n;
            end
         end
      endcase

      m24      = res_n[26:3];
      round_up = res_n[2] & (res_n[1] | res_n[0] | m24[0]);
      mr       = {1'b0, m24} + {24'd0, round_up};
      exp_r    = res_exp + {11'd0, mr[24]};
      frac_r   = mr[24] ? mr[23:1] : mr[22:0];

      if (res_special) begin
         o_d = special_val;
      end else if (res_zero) begin
         o_d = {res_sign, 31'd0};
      end else if (exp_r >= 12'sd255) begin
         o_d = {res_sign, 8'hFF, 23'd0};
      end else if (exp_r <= 12'sd0) begin
         o_d = {res_sign, 31'd0};
      end else begin
         o_d = {res_sign, exp_r[7:0], frac_r};
      end
   end

endmodule

// File: tb/tb_fpu.sv
// Scoreboard bench for fpu: directed vectors plus randomized traffic checked
// against a real-arithmetic reference model with binary32 rounding and flush-to-zero.
`timescale 1ns/1ps
module tb_fpu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] A, B, O;
   logic [1:0]  opcode;

   int checks = 0;
   int passes = 0;

   logic drive_valid = 1'b0;
   logic pipe_v1, pipe_v2;

   typedef struct {
      logic [31:0] exp_o;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      string       name;
   } sb_entry_t;

   sb_entry_t sb_q[$];

   localparam logic [31:0] NAN_C = 32'h7FC0_0000;

   fpu dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A       (A),
      .B       (B),
      .opcode  (opcode),
      .O       (O)
   );

   always #5 clk = ~clk;

   // The result of a vector presented at a negedge appears two rising edges later.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_v1 <= 1'b0;
         pipe_v2 <= 1'b0;
      end else begin
         pipe_v1 <= drive_valid;
         pipe_v2 <= pipe_v1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %08h, expected %08h", name, got, want);
      end
   endtask

   function automatic logic [31:0] infOf(input logic s);
      return {s, 8'hFF, 23'd0};
   endfunction

   function automatic real toReal(input logic [31:0] x);
      if (x[30:23] == 8'd0) return 0.0;
      return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
   endfunction

   // Round an exact-enough double to binary32 (nearest-even), unbounded exponent, then FTZ/overflow.
   function automatic logic [31:0] toBinary32(input real r);
      logic [63:0] bits;
      logic [23:0] mant;
      logic [28:0] tail;
      logic [24:0] mr;
      logic        up;
      int          e;
      bits = $realtobits(r);
      mant = {1'b1, bits[51:29]};
      tail = bits[28:0];
      up   = (tail > 29'h1000_0000) || ((tail == 29'h1000_0000) && mant[0]);
      mr   = {1'b0, mant} + 25'(up);
      e    = int'(bits[62:52]) - 1023 + 127;
      if (mr[24]) begin
         e++;
         mr = mr >> 1;
      end
      if (e >= 255) return infOf(bits[63]);
      if (e <= 0) return {bits[63], 31'd0};
      return {bits[63], 8'(e), mr[22:0]};
   endfunction

   function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      logic na, nb, ia, ib, za, zb, sa, sbe, s;
      real  r;
      na  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nb  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      ia  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      ib  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      za  = (a[30:23] == 8'd0);
      zb  = (b[30:23] == 8'd0);
      sa  = a[31];
      sbe = b[31] ^ (op == 2'b01);
      s   = a[31] ^ b[31];
      if (na || nb) return NAN_C;
      case (op)
         2'b00, 2'b01: begin
            if (ia && ib) return (sa == sbe) ? infOf(sa) : NAN_C;
            if (ia) return infOf(sa);
            if (ib) return infOf(sbe);
            r = (op == 2'b01) ? toReal(a) - toReal(b) : toReal(a) + toReal(b);
            if (r == 0.0) return {sa & sbe, 31'd0};
            return toBinary32(r);
         end
         2'b10: begin
            if ((ia && zb) || (za && ib)) return NAN_C;
            if (ia || ib) return infOf(s);
            if (za || zb) return {s, 31'd0};
            return toBinary32(toReal(a) * toReal(b));
         end
         default: begin
            if ((za && zb) || (ia && ib)) return NAN_C;
            if (ia || zb) return infOf(s);
            if (ib || za) return {s, 31'd0};
            return toBinary32(toReal(a) / toReal(b));
         end
      endcase
   endfunction

   function automatic logic [31:0] randOperand();
      int sel;
      sel = $urandom_range(0, 11);
      if (sel == 0) begin
         case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0001;
            5: return 32'h0012_3456;
            6: return 32'h7F7F_FFFF;
            default: return 32'h0080_0000;
         endcase
      end
      if (sel == 1) return $urandom;
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                input logic [31:0] want, input string name);
      sb_entry_t e;
      @(negedge clk);
      A           = a;
      B           = b;
      opcode      = op;
      drive_valid = 1'b1;
      e.exp_o = want;
      e.a     = a;
      e.b     = b;
      e.op    = op;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   // Monitor: pops the oldest expectation whenever a result is due.
   always @(negedge clk) begin : monitor
      sb_entry_t e;
      if (pipe_v2) begin
         if (sb_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_empty: got %08h, expected no output", O);
         end else begin
            e = sb_q.pop_front();
            checkOutput($sformatf("%s A=%08h B=%08h op=%0d", e.name, e.a, e.b, e.op), O, e.exp_o);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] ra, rb;
      logic [1:0]  rop;
      reset_n = 1'b0;
      A       = '0;
      B       = '0;
      opcode  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_state", O, 32'h0);

      reset_n = 1'b1;
      A = 32'h3F80_0000; B = 32'h4000_0000; opcode = 2'b00;
      @(negedge clk);
      checkOutput("add_latency_edge1", O, 32'h0);
      @(negedge clk);
      checkOutput("add_latency_edge2", O, 32'h4040_0000);

      // Put 2+2 in flight, then reset between edges.
      A = 32'h4000_0000; B = 32'h4000_0000; opcode = 2'b00;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 checkOutput("reset_async_clear", O, 32'h0);
      A = 32'h3F80_0000; B = 32'h4000_0000; opcode = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_edge1", O, 32'h0);
      @(negedge clk);
      checkOutput("post_reset_edge2", O, 32'h4040_0000);

      applyStimulus(32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, "add_1_2");
      applyStimulus(32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h0000_0000, "sub_equal");
      applyStimulus(32'h3FC0_0000, 32'h4000_0000, 2'b10, 32'h4040_0000, "mul_1p5_2");
      applyStimulus(32'h40C0_0000, 32'h4000_0000, 2'b11, 32'h4040_0000, "div_6_2");
      applyStimulus(32'h3F80_0000, 32'h4040_0000, 2'b11, 32'h3EAA_AAAB, "div_1_3");
      applyStimulus(32'h3F80_0000, 32'h0000_0000, 2'b11, 32'h7F80_0000, "div_by_zero");
      applyStimulus(32'h0000_0000, 32'h0000_0000, 2'b11, 32'h7FC0_0000, "div_0_0");
      applyStimulus(32'h7F80_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000, "inf_minus_inf");
      applyStimulus(32'h7FC0_0001, 32'h3F80_0000, 2'b10, 32'h7FC0_0000, "nan_mul");
      applyStimulus(32'h7F7F_FFFF, 32'h4000_0000, 2'b10, 32'h7F80_0000, "mul_overflow");
      applyStimulus(32'h0080_0000, 32'h3F00_0000, 2'b10, 32'h0000_0000, "mul_flush");
      applyStimulus(32'h8000_0000, 32'h8000_0000, 2'b00, 32'h8000_0000, "negzero_add");

      for (int n = 0; n < 1000; n++) begin
         ra  = randOperand();
         rb  = randOperand();
         rop = 2'($urandom_range(0, 3));
         if (rop[1] == 1'b0 && $urandom_range(0, 5) == 0) begin
            rb = {1'($urandom_range(0, 1)), ra[30:0] ^ {23'd0, 8'($urandom_range(0, 255))}};
         end
         applyStimulus(ra, rb, rop, refModel(ra, rb, rop), "random");
      end

      @(negedge clk);
      drive_valid = 1'b0;
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
